// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the CPU load/store unit (port A)
// and the program/data loader (port B). One request is accepted per idle
// cycle; the memory strobes are then held for WAIT_CYCLES cycles. Read data
// goes into a per-port register, and a one-cycle done pulse completes the
// access.
//
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration.
// When it is undefined, A always wins a conflict.
//
// Parameters
//   AW           address width
//   DW           data width
//   WAIT_CYCLES  cycles the strobes stay asserted per access (1..15)
//
// Ports
//   Clk, Rst_n            clock (rising edge), asynchronous active-low reset
//   A_/B_req,we,addr,     requester side; hold stable until gnt
//   A_/B_wdata
//   A_/B_gnt              combinational grant, one cycle in IDLE
//   A_/B_done             registered one-cycle completion pulse
//   A_/B_rdata            per-port read data, updated only by that port's reads
//   Mem_addr, Mem_wdata   memory address / write data (hold last latched value)
//   Mem_read, Mem_write   memory strobes, asserted only in ACCESS
//   Mem_rdata             memory read data, combinational from Mem_addr
//   Busy                  access in progress (state != IDLE)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          A_req,
    input  logic          A_we,
    input  logic [AW-1:0] A_addr,
    input  logic [DW-1:0] A_wdata,
    input  logic          B_req,
    input  logic          B_we,
    input  logic [AW-1:0] B_addr,
    input  logic [DW-1:0] B_wdata,
    output logic          A_gnt,
    output logic          B_gnt,
    output logic          A_done,
    output logic          B_done,
    output logic [DW-1:0] A_rdata,
    output logic [DW-1:0] B_rdata,
    output logic [AW-1:0] Mem_addr,
    output logic [DW-1:0] Mem_wdata,
    output logic          Mem_read,
    output logic          Mem_write,
    input  logic [DW-1:0] Mem_rdata,
    output logic          Busy
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 0 = port A, 1 = port B
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          a_done_q, a_done_d;
    logic          b_done_q, b_done_d;
    logic          pick_b;
    logic          grant;

`ifdef DMEM_ARB_RR_EN
    // Last winner: 1 = B. Resetting it to B makes A win the first conflict.
    logic          last_b_q, last_b_d;

    // On a conflict the port that did not win last time goes first.
    assign pick_b = B_req && (!A_req || !last_b_q);
`else
    assign pick_b = B_req && !A_req;
`endif

    // Grants are suppressed while reset is held, even though the state is IDLE.
    always_comb begin
        grant = Rst_n && (state_q == IDLE) && (A_req || B_req);
        A_gnt = grant && !pick_b;
        B_gnt = grant && pick_b;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_b_d  = last_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (A_req || B_req) begin
                    state_d = ACCESS;
                    owner_d = pick_b;
                    we_d    = pick_b ? B_we    : A_we;
                    addr_d  = pick_b ? B_addr  : A_addr;
                    wdata_d = pick_b ? B_wdata : A_wdata;
                    cnt_d   = CNT_LOAD;
`ifdef DMEM_ARB_RR_EN
                    last_b_d = pick_b;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    // Only reads touch the owner's rdata register.
                    if (!we_q) begin
                        if (owner_q) b_rdata_d = Mem_rdata;
                        else         a_rdata_d = Mem_rdata;
                    end
                    if (owner_q) b_done_d = 1'b1;
                    else         a_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 4'd0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_b_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
`ifdef DMEM_ARB_RR_EN
            last_b_q  <= last_b_d;
`endif
        end
    end

    // Strobes decode straight from the state, so an asynchronous reset
    // removes them in the same cycle.
    assign Mem_read  = (state_q == ACCESS) && !we_q;
    assign Mem_write = (state_q == ACCESS) && we_q;
    assign Mem_addr  = addr_q;
    assign Mem_wdata = wdata_q;
    assign A_rdata   = a_rdata_q;
    assign B_rdata   = b_rdata_q;
    assign A_done    = a_done_q;
    assign B_done    = b_done_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Three arbiter instances with WAIT_CYCLES = 1, 2 and 4. Each instance has its
// own behavioural memory and shares the clock and reset. Expected done events
// (instance, port, cycle, read data) are queued when a grant is observed. A
// monitor records the actual done pulses, and each test drains both queues
// against each other.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic        a_req [3];
    logic        a_we [3];
    logic [15:0] a_addr [3];
    logic [15:0] a_wdata [3];
    logic        b_req [3];
    logic        b_we [3];
    logic [15:0] b_addr [3];
    logic [15:0] b_wdata [3];
    logic        a_gnt [3];
    logic        b_gnt [3];
    logic        a_done [3];
    logic        b_done [3];
    logic [15:0] a_rdata [3];
    logic [15:0] b_rdata [3];
    logic [15:0] mem_addr [3];
    logic [15:0] mem_wdata [3];
    logic        mem_read [3];
    logic        mem_write [3];
    logic [15:0] mem_rdata [3];
    logic        busy [3];

    logic        pl_en [3];
    logic [7:0]  pl_addr [3];
    logic [15:0] pl_data [3];

    typedef struct {
        int          inst;
        int          port;   // 0 = A, 1 = B
        int          cyc;
        logic [15:0] rdata;
        logic        chk;    // compare rdata only for reads
    } ev_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic last_b [3];        // bench model of the round-robin pointer

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int WC = (i == 0) ? 1 : ((i == 1) ? 2 : 4);
        logic [15:0] mem [256];

        always @(posedge clk) begin
            if (pl_en[i])          mem[pl_addr[i]] <= pl_data[i];
            else if (mem_write[i]) mem[mem_addr[i][7:0]] <= mem_wdata[i];
        end
        assign mem_rdata[i] = mem[mem_addr[i][7:0]];

        dmem_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(WC)) u_dut (
            .Clk       (clk),
            .Rst_n     (rst_n),
            .A_req     (a_req[i]),
            .A_we      (a_we[i]),
            .A_addr    (a_addr[i]),
            .A_wdata   (a_wdata[i]),
            .B_req     (b_req[i]),
            .B_we      (b_we[i]),
            .B_addr    (b_addr[i]),
            .B_wdata   (b_wdata[i]),
            .A_gnt     (a_gnt[i]),
            .B_gnt     (b_gnt[i]),
            .A_done    (a_done[i]),
            .B_done    (b_done[i]),
            .A_rdata   (a_rdata[i]),
            .B_rdata   (b_rdata[i]),
            .Mem_addr  (mem_addr[i]),
            .Mem_wdata (mem_wdata[i]),
            .Mem_read  (mem_read[i]),
            .Mem_write (mem_write[i]),
            .Mem_rdata (mem_rdata[i]),
            .Busy      (busy[i])
        );
    end

    // Done monitor: records every completion pulse with its cycle number.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (a_done[k] === 1'b1) obs_q.push_back('{k, 0, cyc, a_rdata[k], 1'b1});
            if (b_done[k] === 1'b1) obs_q.push_back('{k, 1, cyc, b_rdata[k], 1'b1});
        end
    end

    task automatic preload(input int k, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en[k] = 1'b1; pl_addr[k] = a; pl_data[k] = d;
        @(negedge clk);
        pl_en[k] = 1'b0;
    endtask

    task automatic test_reset;
        ev_t e, o;
        int  c;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_req[k] = 1'b1; a_we[k] = 1'b1; a_addr[k] = 16'd0; a_wdata[k] = 16'd0;
            b_req[k] = 1'b1; b_we[k] = 1'b1; b_addr[k] = 16'd0; b_wdata[k] = 16'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({a_gnt[k], b_gnt[k], a_done[k], b_done[k], mem_read[k], mem_write[k], busy[k]} !== 7'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: gnt/done/strobe/busy=%b required 0000000", k,
                         {a_gnt[k], b_gnt[k], a_done[k], b_done[k], mem_read[k], mem_write[k], busy[k]});
            end
            checks++;
            if (a_rdata[k] !== 16'd0) begin
                errors++; $display("FAIL reset_a_rdata inst%0d: got %h required 0000", k, a_rdata[k]);
            end
            checks++;
            if (b_rdata[k] !== 16'd0) begin
                errors++; $display("FAIL reset_b_rdata inst%0d: got %h required 0000", k, b_rdata[k]);
            end
            checks++;
            if (mem_addr[k] !== 16'd0) begin
                errors++; $display("FAIL reset_mem_addr inst%0d: got %h required 0000", k, mem_addr[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({a_gnt[k], b_gnt[k]} !== 2'b10) begin
                errors++; $display("FAIL release_gnt inst%0d: gnt A,B=%b required 10", k, {a_gnt[k], b_gnt[k]});
            end
            exp_q.push_back('{k, 0, c + wc(k) + 1, 16'd0, 1'b0});
            last_b[k] = 1'b0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            a_req[k] = 1'b0; b_req[k] = 1'b0;
        end
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL reset_done: missing pulse, required inst%0d port%0d cycle %0d", e.inst, e.port, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.port !== e.port || o.cyc !== e.cyc || (e.chk && o.rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL reset_done: got inst%0d port%0d cycle %0d rdata %h, required inst%0d port%0d cycle %0d rdata %h",
                             o.inst, o.port, o.cyc, o.rdata, e.inst, e.port, e.cyc, e.rdata);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL reset_extra_done: got %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_read;
        ev_t e, o;
        int  c;
        preload(0, 8'd3, 16'h0007);
        a_we[0] = 1'b0; a_addr[0] = 16'd3; a_req[0] = 1'b1;
        #1;
        c = cyc;
        checks++;
        if (a_gnt[0] !== 1'b1) begin
            errors++; $display("FAIL read_gnt: got %b required 1", a_gnt[0]);
        end
        exp_q.push_back('{0, 0, c + 2, 16'h0007, 1'b1});
        last_b[0] = 1'b0;
        @(posedge clk); #1;
        a_req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read[0], mem_write[0]} !== 2'b10) begin
            errors++; $display("FAIL read_strobe: read,write=%b required 10", {mem_read[0], mem_write[0]});
        end
        checks++;
        if (mem_addr[0] !== 16'd3) begin
            errors++; $display("FAIL read_mem_addr: got %h required 0003", mem_addr[0]);
        end
        @(negedge clk);
        checks++;
        if (mem_read[0] !== 1'b0) begin
            errors++; $display("FAIL read_strobe_resp: got %b required 0", mem_read[0]);
        end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL read_done: missing pulse, required inst%0d port%0d cycle %0d", e.inst, e.port, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.port !== e.port || o.cyc !== e.cyc || (e.chk && o.rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL read_done: got inst%0d port%0d cycle %0d rdata %h, required inst%0d port%0d cycle %0d rdata %h",
                             o.inst, o.port, o.cyc, o.rdata, e.inst, e.port, e.cyc, e.rdata);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL read_extra_done: got %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_write_read;
        ev_t e, o;
        int  c;
        @(negedge clk);
        b_we[0] = 1'b1; b_addr[0] = 16'd5; b_wdata[0] = 16'h00AA; b_req[0] = 1'b1;
        #1;
        c = cyc;
        checks++;
        if ({a_gnt[0], b_gnt[0]} !== 2'b01) begin
            errors++; $display("FAIL wr_gnt: gnt A,B=%b required 01", {a_gnt[0], b_gnt[0]});
        end
        exp_q.push_back('{0, 1, c + 2, 16'd0, 1'b0});
        last_b[0] = 1'b1;
        @(posedge clk); #1;
        b_req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read[0], mem_write[0]} !== 2'b01) begin
            errors++; $display("FAIL wr_strobe: read,write=%b required 01", {mem_read[0], mem_write[0]});
        end
        checks++;
        if (mem_wdata[0] !== 16'h00AA || mem_addr[0] !== 16'd5) begin
            errors++; $display("FAIL wr_bus: addr %h wdata %h required addr 0005 wdata 00aa", mem_addr[0], mem_wdata[0]);
        end
        @(negedge clk);
        checks++;
        if (mem_write[0] !== 1'b0) begin
            errors++; $display("FAIL wr_strobe_resp: got %b required 0", mem_write[0]);
        end
        @(negedge clk);
        b_we[0] = 1'b0; b_req[0] = 1'b1;
        #1;
        c = cyc;
        exp_q.push_back('{0, 1, c + 2, 16'h00AA, 1'b1});
        @(posedge clk); #1;
        b_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_rdata[0] !== 16'h0007) begin
            errors++; $display("FAIL wr_a_rdata_held: got %h required 0007", a_rdata[0]);
        end
        checks++;
        if (b_rdata[0] !== 16'h00AA) begin
            errors++; $display("FAIL wr_b_rdata_held: got %h required 00aa", b_rdata[0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL wr_done: missing pulse, required inst%0d port%0d cycle %0d", e.inst, e.port, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.port !== e.port || o.cyc !== e.cyc || (e.chk && o.rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL wr_done: got inst%0d port%0d cycle %0d rdata %h, required inst%0d port%0d cycle %0d rdata %h",
                             o.inst, o.port, o.cyc, o.rdata, e.inst, e.port, e.cyc, e.rdata);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL wr_extra_done: got %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_conflict;
        ev_t  e, o;
        logic ea, eb;
        @(negedge clk);
        a_we[1] = 1'b1; a_addr[1] = 16'd10; a_wdata[1] = 16'h1111;
        b_we[1] = 1'b1; b_addr[1] = 16'd11; b_wdata[1] = 16'h2222;
        a_req[1] = 1'b1; b_req[1] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            #1;
            ea = 1'b0; eb = 1'b0;
            if (t % 4 == 0) begin
                if (RR && !last_b[1]) eb = 1'b1;
                else                  ea = 1'b1;
            end
            checks++;
            if ({a_gnt[1], b_gnt[1]} !== {ea, eb}) begin
                errors++; $display("FAIL conflict_gnt t=%0d: gnt A,B=%b required %b", t, {a_gnt[1], b_gnt[1]}, {ea, eb});
            end
            if (ea || eb) begin
                exp_q.push_back('{1, eb ? 1 : 0, cyc + 3, 16'd0, 1'b0});
                last_b[1] = eb;
            end
            @(negedge clk);
        end
        a_req[1] = 1'b0; b_req[1] = 1'b0;
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL conflict_done: missing pulse, required inst%0d port%0d cycle %0d", e.inst, e.port, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.port !== e.port || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL conflict_done: got inst%0d port%0d cycle %0d, required inst%0d port%0d cycle %0d",
                             o.inst, o.port, o.cyc, e.inst, e.port, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL conflict_extra_done: got %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        a_we[2] = 1'b1; a_addr[2] = 16'd20; a_wdata[2] = 16'h0055; a_req[2] = 1'b1;
        #1;
        checks++;
        if (a_gnt[2] !== 1'b1) begin
            errors++; $display("FAIL mid_gnt: got %b required 1", a_gnt[2]);
        end
        @(posedge clk); #1;
        a_req[2] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mem_write[2], busy[2]} !== 2'b11) begin
            errors++; $display("FAIL mid_access2: write,busy=%b required 11", {mem_write[2], busy[2]});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_write[2], busy[2]} !== 2'b00) begin
            errors++; $display("FAIL mid_strobe_drop: write,busy=%b required 00", {mem_write[2], busy[2]});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) last_b[k] = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++; $display("FAIL mid_idle_after: busy=%b required 0", busy[2]);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL mid_no_done: got %0d done pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_req[k] = 1'b0; a_we[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0;
            b_req[k] = 1'b0; b_we[k] = 1'b0; b_addr[k] = '0; b_wdata[k] = '0;
            pl_en[k] = 1'b0; pl_addr[k] = '0; pl_data[k] = '0;
            last_b[k] = 1'b1;
        end
        test_reset();
        test_read();
        test_write_read();
        test_conflict();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the CPU data memory. Shares the single data-memory port between the CPU load/store unit (port A) and the program/data loader (port B). Serialises the requests, drives the memory strobes for a fixed number of cycles, and returns registered read data with a one-cycle completion pulse. Sits between the requesters and the data memory; the memory itself is unchanged.

## Interface
- AW, 16, address width
- DW, 16, data width
- WAIT_CYCLES, 1, cycles the memory strobes stay asserted per access; legal range 1-15
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- A_req / B_req  in  1  access request; hold with address and data stable until grant
- A_we / B_we  in  1  1 = write, 0 = read
- A_addr / B_addr  in  AW  word address
- A_wdata / B_wdata  in  DW  write data
- A_gnt / B_gnt  out  1  combinational; high for one cycle in IDLE when that port wins
- A_done / B_done  out  1  registered one-cycle completion pulse
- A_rdata / B_rdata  out  DW  read data; valid with done on reads, held otherwise
- Mem_addr  out  AW  memory address
- Mem_wdata  out  DW  memory write data
- Mem_read / Mem_write  out  1  memory strobes
- Mem_rdata  in  DW  memory read data, combinational from Mem_addr
- Busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, the winner's gnt is high that cycle.
  - At the edge, latch owner, we, addr and wdata; load the wait counter with WAIT_CYCLES-1; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Mem_addr and Mem_wdata come from the latched values.
  - Mem_write = latched we; Mem_read = !we.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: for a read, capture Mem_rdata into the owner's rdata register; go to RESP.
- RESP:
  - Owner's done = 1 for exactly one cycle; strobes low.
  - Next state is IDLE unconditionally. A request held high is re-arbitrated there.
- Arbitration: fixed priority, A over B (see Configuration for round-robin).
- Outside ACCESS, Mem_read and Mem_write are 0. Mem_addr and Mem_wdata hold their last latched values.
- A write leaves the owner's rdata unchanged. The non-owner's rdata never changes.
- A requester that drops req before grant is simply not served; no error.
- Reset values: state IDLE; all gnt, done and strobe outputs 0; Mem_addr, Mem_wdata, A_rdata and B_rdata 0; Busy 0; round-robin pointer favours A.
- Reset asserted mid-access:
  - Strobes drop immediately (asynchronous).
  - No done is issued and the latched request is discarded.
  - Memory contents are whatever the write strobe already produced.

## Timing
- Grant to done: WAIT_CYCLES+1 edges. Done occurs in cycle g+WAIT_CYCLES+1, where g is the grant cycle.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Read data is stable from the done cycle until the next read completion for that port.
- Simultaneous A and B requests in IDLE produce exactly one gnt. The loser's req must stay high; it is granted at the next IDLE at the earliest.
- The wait counter is 4 bits wide. WAIT_CYCLES=1 gives a single ACCESS cycle.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last winner.
  - On a conflict, the port that did not win last is granted.
  - A lone requester always wins and updates the pointer.
- DMEM_ARB_RR_EN undefined: fixed priority, A always wins conflicts. No pointer register exists, so B can be starved.

## Test plan
- Reset: hold Rst_n=0 with both reqs high → all gnt, done and strobes 0, Busy 0, rdata 0. Release → A_gnt in the first IDLE cycle.
- Read, WAIT_CYCLES=1: memory model preloaded with addr 3 = 0x0007; A read at addr 3 → A_gnt cycle 0, Mem_read with Mem_addr=3 in cycle 1, A_done with A_rdata=0x0007 in cycle 2.
- Write then read: B writes 0x00AA to addr 5, then B reads addr 5 → Mem_write for one cycle with Mem_wdata=0x00AA; the read returns B_rdata=0x00AA; A_rdata unchanged.
- Conflict, fixed priority: A and B request continuously with WAIT_CYCLES=2 → grants A,A,A…, B never granted; done every 4 cycles.
- Conflict with DMEM_ARB_RR_EN: same stimulus → grants alternate A,B,A,B; each port's done every 8 cycles.
- Reset mid-access: WAIT_CYCLES=4, pull Rst_n low in the 2nd ACCESS cycle → Mem_write drops in that cycle, no done pulse, FSM in IDLE after release.
